// File: rtl/exceptionull_pkg.sv
// -----------------------------------------------------------------------------
// exceptionull_pkg
// Shared definitions for the ExceptioNull 8-bit datapath sequencer:
//   - 4-bit opcode constants (ir[7:4])
//   - ALU control codes driven onto alu_control
//   - sequencer state encoding (also visible on the debug state port)
//   - instruction class used to steer the FSM
//   - PC arithmetic helpers (8-bit wrapping)
// -----------------------------------------------------------------------------
package exceptionull_pkg;

   localparam int OPCODE_W = 4;
   localparam int ALU_W    = 3;
   localparam int PC_W     = 8;

   // Opcodes
   localparam logic [OPCODE_W-1:0] OP_MOVE = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_AND  = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_NOT  = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_NOR  = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_SLT  = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_SLL  = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_SRL  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_J    = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_JAL  = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_LW   = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_SW   = 4'hB;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'hC;
   localparam logic [OPCODE_W-1:0] OP_BNE  = 4'hD;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_LI   = 4'hF;

   // ALU control codes
   localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
   localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;
   localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
   localparam logic [ALU_W-1:0] ALU_NOR  = 3'b100;
   localparam logic [ALU_W-1:0] ALU_SLT  = 3'b101;
   localparam logic [ALU_W-1:0] ALU_SLL  = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SRL  = 3'b111;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } seq_state_e;

   // Instruction classes, as far as the FSM cares
   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_JUMP   = 3'd4
   } instr_class_e;

   // Sign-extend the 4-bit jump/branch offset held in ir[3:0].
   function automatic logic [PC_W-1:0] sext_offset(input logic [3:0] off);
      return {{(PC_W-4){off[3]}}, off};
   endfunction

   // Relative PC update, wrapping modulo 256.
   function automatic logic [PC_W-1:0] pc_relative(input logic [PC_W-1:0] pc_cur,
                                                   input logic [3:0]      off);
      return pc_cur + sext_offset(off);
   endfunction

endpackage

// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
// Pure combinational opcode decode for the multicycle sequencer.
// Ports:
//   opcode      in   4  ir[7:4]
//   alu_control out  3  ALU operation for this opcode
//   alu_src     out  1  1 = zero-extended ir[1:0] as operand B
//   cls         out  3  instruction class (ALU/LOAD/STORE/BRANCH/JUMP)
//   is_jal      out  1  opcode is jal (link write in EXEC)
//   is_bne      out  1  branch sense: 1 = taken on non-zero, 0 = taken on zero
//   is_load     out  1  opcode is lw (write-back from data memory)
// -----------------------------------------------------------------------------
module seq_decoder
   import exceptionull_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALU_W-1:0]    alu_control,
   output logic                alu_src,
   output instr_class_e        cls,
   output logic                is_jal,
   output logic                is_bne,
   output logic                is_load
);

   always_comb begin
      alu_control = ALU_PASS;
      alu_src     = 1'b0;
      cls         = CLS_ALU;
      case (opcode)
         OP_MOVE: alu_control = ALU_PASS;
         OP_ADD:  alu_control = ALU_ADD;
         OP_AND:  alu_control = ALU_AND;
         // not is realised as NOR with rs routed to both operands by the datapath
         OP_NOT:  alu_control = ALU_NOR;
         OP_NOR:  alu_control = ALU_NOR;
         OP_SLT:  alu_control = ALU_SLT;
         OP_SLL: begin
            alu_control = ALU_SLL;
            alu_src     = 1'b1;
         end
         OP_SRL: begin
            alu_control = ALU_SRL;
            alu_src     = 1'b1;
         end
         OP_J: begin
            alu_control = ALU_PASS;
            cls         = CLS_JUMP;
         end
         OP_JAL: begin
            alu_control = ALU_PASS;
            cls         = CLS_JUMP;
         end
         OP_LW: begin
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
            cls         = CLS_LOAD;
         end
         OP_SW: begin
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
            cls         = CLS_STORE;
         end
         OP_BEQ: begin
            alu_control = ALU_SUB;
            cls         = CLS_BRANCH;
         end
         OP_BNE: begin
            alu_control = ALU_SUB;
            cls         = CLS_BRANCH;
         end
         OP_ADDI: begin
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
         end
         OP_LI: begin
            alu_control = ALU_PASS;
            alu_src     = 1'b1;
         end
         default: begin
            alu_control = ALU_PASS;
            alu_src     = 1'b0;
            cls         = CLS_ALU;
         end
      endcase
   end

   assign is_jal  = (opcode == OP_JAL);
   assign is_bne  = (opcode == OP_BNE);
   assign is_load = (opcode == OP_LW);

endmodule

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle fetch/decode/execute sequencer for the ExceptioNull 8-bit
// datapath. Owns the PC and IR and steps the datapath one phase per state,
// stalling in FETCH/MEM until the respective memory acknowledges.
//
// Ports:
//   clk            in   1  rising-edge clock
//   reset          in   1  synchronous, active high
//   run            in   1  permits starting the next instruction
//   imem_rdata     in   8  instruction word, valid with imem_ack
//   imem_ack       in   1  instruction memory done
//   dmem_ack       in   1  data memory done
//   alu_zero       in   1  ALU result is zero (branch condition)
//   imem_req       out  1  high throughout FETCH
//   pc             out  8  program counter
//   ir             out  8  instruction register
//   dmem_req       out  1  high throughout MEM
//   dmem_we        out  1  store in MEM
//   alu_control    out  3  ALU operation
//   alu_src        out  1  immediate operand select
//   wren_reg       out  1  register-file write strobe
//   datamem_toreg  out  1  write-back from data memory
//   link_wr        out  1  jal link write of pc into r3
//   state          out  3  debug view of the FSM state
//
// state  | meaning
// IDLE   | parked; leaves on run
// FETCH  | instruction request outstanding; IR/PC load on imem_ack
// DECODE | one quiet cycle for the decoder to settle
// EXEC   | ALU active; jumps/branches resolve and retire here
// MEM    | data request outstanding until dmem_ack
// WB     | one-cycle register-file write
// -----------------------------------------------------------------------------
module multicycle_sequencer
   import exceptionull_pkg::*;
#(
   parameter logic [7:0] PC_RESET = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [7:0]       imem_rdata,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   input  logic             alu_zero,
   output logic             imem_req,
   output logic [7:0]       pc,
   output logic [7:0]       ir,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [ALU_W-1:0] alu_control,
   output logic             alu_src,
   output logic             wren_reg,
   output logic             datamem_toreg,
   output logic             link_wr,
   output logic [2:0]       state
);

   seq_state_e   state_q, state_d;
   logic [7:0]   pc_q, pc_d;
   logic [7:0]   ir_q, ir_d;

   logic [ALU_W-1:0] dec_alu_control;
   logic             dec_alu_src;
   instr_class_e     dec_cls;
   logic             dec_is_jal;
   logic             dec_is_bne;
   logic             dec_is_load;

   logic             branch_taken;
   logic             redirect;
   seq_state_e       retire_state;

   seq_decoder u_seq_decoder (
      .opcode      (ir_q[7:4]),
      .alu_control (dec_alu_control),
      .alu_src     (dec_alu_src),
      .cls         (dec_cls),
      .is_jal      (dec_is_jal),
      .is_bne      (dec_is_bne),
      .is_load     (dec_is_load)
   );

   // beq takes on zero, bne on non-zero
   assign branch_taken = (dec_cls == CLS_BRANCH) && (dec_is_bne ? !alu_zero : alu_zero);
   assign redirect     = (dec_cls == CLS_JUMP) || branch_taken;

   // run is only looked at when an instruction retires
   assign retire_state = run ? ST_FETCH : ST_IDLE;

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + 8'd1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // offset is relative to the already-incremented PC
            if (redirect) begin
               pc_d = pc_relative(pc_q, ir_q[3:0]);
            end
            case (dec_cls)
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_ALU:             state_d = ST_WB;
               default:             state_d = retire_state;
            endcase
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_d = (dec_cls == CLS_STORE) ? retire_state : ST_WB;
            end
         end
         ST_WB: begin
            state_d = retire_state;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_RESET;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // ------------------------------------------------------------ Moore outputs
   always_comb begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      alu_control   = ALU_PASS;
      alu_src       = 1'b0;
      wren_reg      = 1'b0;
      datamem_toreg = 1'b0;
      link_wr       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
         end
         ST_EXEC: begin
            alu_control = dec_alu_control;
            alu_src     = dec_alu_src;
            link_wr     = dec_is_jal;
            wren_reg    = dec_is_jal;
         end
         ST_MEM: begin
            // keep the address computation on the ALU while the access is pending
            alu_control = dec_alu_control;
            alu_src     = dec_alu_src;
            dmem_req    = 1'b1;
            dmem_we     = (dec_cls == CLS_STORE);
         end
         ST_WB: begin
            // ALU result must stay valid for the ALU write-back path
            alu_control   = dec_alu_control;
            alu_src       = dec_alu_src;
            wren_reg      = 1'b1;
            datamem_toreg = dec_is_load;
         end
         default: begin
         end
      endcase
   end

   assign pc    = pc_q;
   assign ir    = ir_q;
   assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
   import exceptionull_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [7:0] imem_rdata;
   logic       imem_ack;
   logic       dmem_ack;
   logic       alu_zero;
   logic       imem_req;
   logic [7:0] pc;
   logic [7:0] ir;
   logic       dmem_req;
   logic       dmem_we;
   logic [2:0] alu_control;
   logic       alu_src;
   logic       wren_reg;
   logic       datamem_toreg;
   logic       link_wr;
   logic [2:0] state;

   multicycle_sequencer #(.PC_RESET(8'h00)) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .imem_rdata    (imem_rdata),
      .imem_ack      (imem_ack),
      .dmem_ack      (dmem_ack),
      .alu_zero      (alu_zero),
      .imem_req      (imem_req),
      .pc            (pc),
      .ir            (ir),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .alu_control   (alu_control),
      .alu_src       (alu_src),
      .wren_reg      (wren_reg),
      .datamem_toreg (datamem_toreg),
      .link_wr       (link_wr),
      .state         (state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference tables straight from the opcode map
   int exp_alu [16] = '{0, 1, 3, 4, 4, 5, 6, 7, 0, 0, 1, 1, 2, 2, 1, 0};
   int exp_src [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

   logic [7:0] pc_model;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Runs one instruction starting at a negedge in FETCH. iw/dw are the wait
   // cycles before each ack; run_end is the run level from EXEC onward.
   task automatic exec_instr(input logic [7:0] instr, input int iw, input int dw,
                             input bit z, input bit run_end);
      int         op;
      int         off;
      bit         is_mem, is_store, is_load, is_alu, is_jump, is_branch, is_jal, taken;
      int         exp_st[$];
      logic [7:0] pc_fetch, pc_end, link_pc;
      int         n_ireq, n_dreq, n_dwe, n_wren, n_link, n_dtr, quiet_bad;
      int         ireq_seen, dreq_seen;

      op        = int'(instr[7:4]);
      off       = instr[3] ? int'(instr[3:0]) - 16 : int'(instr[3:0]);
      is_jump   = (op == 8) || (op == 9);
      is_jal    = (op == 9);
      is_branch = (op == 12) || (op == 13);
      is_load   = (op == 10);
      is_store  = (op == 11);
      is_mem    = is_load || is_store;
      is_alu    = !(is_jump || is_branch || is_mem);
      taken     = (op == 12) ? z : ((op == 13) ? !z : 1'b0);

      pc_fetch = pc_model + 8'd1;
      pc_end   = (is_jump || taken) ? 8'(int'(pc_fetch) + off) : pc_fetch;

      repeat (iw + 1) exp_st.push_back(int'(ST_FETCH));
      exp_st.push_back(int'(ST_DECODE));
      exp_st.push_back(int'(ST_EXEC));
      if (is_mem) repeat (dw + 1) exp_st.push_back(int'(ST_MEM));
      if (is_alu || is_load) exp_st.push_back(int'(ST_WB));

      n_ireq = 0; n_dreq = 0; n_dwe = 0; n_wren = 0; n_link = 0; n_dtr = 0;
      quiet_bad = 0; ireq_seen = 0; dreq_seen = 0; link_pc = 8'h00;
      alu_zero = z;

      for (int k = 0; k < exp_st.size(); k++) begin
         chk("state_seq", state, exp_st[k]);
         if (exp_st[k] == int'(ST_EXEC)) begin
            chk("alu_control", alu_control, exp_alu[op]);
            chk("alu_src", alu_src, exp_src[op]);
            run = run_end;
         end
         n_ireq += int'(imem_req);
         n_dreq += int'(dmem_req);
         n_dwe  += int'(dmem_we);
         n_wren += int'(wren_reg);
         n_link += int'(link_wr);
         n_dtr  += int'(datamem_toreg);
         if (link_wr) link_pc = pc;
         if ((exp_st[k] == int'(ST_FETCH) || exp_st[k] == int'(ST_DECODE)) &&
             (wren_reg || link_wr || dmem_req || dmem_we || datamem_toreg))
            quiet_bad++;
         imem_ack = imem_req && (ireq_seen == iw);
         if (imem_req) ireq_seen++;
         imem_rdata = imem_ack ? instr : 8'($urandom);
         dmem_ack = dmem_req && (dreq_seen == dw);
         if (dmem_req) dreq_seen++;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;

      chk("end_state", state, run_end ? int'(ST_FETCH) : int'(ST_IDLE));
      chk("pc", pc, pc_end);
      chk("ir", ir, instr);
      chk("imem_req_cycles", n_ireq, iw + 1);
      chk("dmem_req_cycles", n_dreq, is_mem ? dw + 1 : 0);
      chk("dmem_we_cycles", n_dwe, is_store ? dw + 1 : 0);
      chk("wren_cycles", n_wren, (is_alu || is_load || is_jal) ? 1 : 0);
      chk("link_cycles", n_link, is_jal ? 1 : 0);
      chk("datamem_toreg_cycles", n_dtr, is_load ? 1 : 0);
      chk("quiet_strobes", quiet_bad, 0);
      if (is_jal) chk("link_pc", link_pc, pc_fetch);
      pc_model = pc_end;
   endtask

   initial begin
      reset = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
      imem_rdata = 8'hFF; alu_zero = 1'b0; pc_model = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_state", state, ST_IDLE);
      chk("rst_pc", pc, 8'h00);
      chk("rst_ir", ir, 8'h00);
      chk("rst_strobes", {imem_req, dmem_req, dmem_we, wren_reg, datamem_toreg, link_wr}, 6'b0);
      chk("rst_alu", {alu_control, alu_src}, 4'b0);
      reset = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_no_run", state, ST_IDLE);
      chk("idle_no_req", imem_req, 1'b0);
      run = 1'b1;
      @(negedge clk);
      chk("start_fetch", state, ST_FETCH);

      // add, then lw with a 3-cycle data wait
      exec_instr(8'h1E, 0, 0, 1'b0, 1'b1);
      exec_instr(8'hA5, 0, 3, 1'b0, 1'b1);
      // walk pc to 4, then beq taken / not taken, bne
      exec_instr(8'h00, 0, 0, 1'b0, 1'b1);
      exec_instr(8'h00, 0, 0, 1'b0, 1'b1);
      exec_instr(8'hCE, 0, 0, 1'b1, 1'b1);
      exec_instr(8'h00, 1, 0, 1'b0, 1'b1);
      exec_instr(8'hCE, 0, 0, 1'b0, 1'b1);
      exec_instr(8'hDE, 0, 0, 1'b1, 1'b1);
      exec_instr(8'hDE, 2, 0, 1'b0, 1'b1);
      exec_instr(8'hB1, 1, 2, 1'b0, 1'b1);

      // reset while a load is waiting in MEM; the ack during reset is ignored
      imem_rdata = 8'hA5; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mem_before_reset", dmem_req, 1'b1);
      reset = 1'b1; dmem_ack = 1'b1;
      @(negedge clk);
      chk("reset_mem_state", state, ST_IDLE);
      chk("reset_mem_dreq", dmem_req, 1'b0);
      chk("reset_mem_pc", pc, 8'h00);
      reset = 1'b0; dmem_ack = 1'b0; pc_model = 8'h00;
      @(negedge clk);
      chk("after_reset_fetch", state, ST_FETCH);

      // j -3 from 0 lands at FE; jal +3 at FE links FF and wraps to 02
      exec_instr(8'h8D, 0, 0, 1'b0, 1'b1);
      exec_instr(8'h93, 0, 0, 1'b0, 1'b1);

      // run dropped during EXEC of an ALU op
      exec_instr(8'h1E, 1, 0, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("parked_state", state, ST_IDLE);
         chk("parked_imem_req", imem_req, 1'b0);
      end
      run = 1'b1;
      @(negedge clk);
      chk("restart_fetch", state, ST_FETCH);

      for (int n = 0; n < 200; n++) begin
         logic [7:0] instr;
         bit         re;
         instr = 8'($urandom);
         re    = ($urandom_range(0, 7) != 0);
         exec_instr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), re);
         if (!re) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               chk("rand_idle", state, ST_IDLE);
               chk("rand_idle_req", imem_req, 1'b0);
            end
            run = 1'b1;
            @(negedge clk);
            chk("rand_restart", state, ST_FETCH);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the 8-bit ExceptioNull datapath. It fetches one 8-bit instruction at a time, decodes the 4-bit opcode in `ir[7:4]`, and steps the ALU, register file and data memory through FETCH/DECODE/EXEC/MEM/WB. It owns the program counter and the instruction register. It replaces the purely combinational decode with a state machine that tolerates wait states on both memory ports.

## Interface
- `PC_RESET`, default 8'h00: PC value loaded on reset.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; PC←PC_RESET, state←IDLE.
- `run`  in  1  level; permits leaving IDLE and starting the next instruction.
- `imem_rdata`  in  8  instruction word; valid when `imem_ack`.
- `imem_ack`  in  1  instruction memory done; may arrive in the same cycle as the request.
- `dmem_ack`  in  1  data memory done.
- `alu_zero`  in  1  ALU result==0; sampled in EXEC.
- `imem_req`  out  1  held high throughout FETCH.
- `pc`  out  8  current PC.
- `ir`  out  8  instruction register.
- `dmem_req`  out  1  held high throughout MEM.
- `dmem_we`  out  1  high during MEM for sw.
- `alu_control`  out  3  ALU opcode from the package.
- `alu_src`  out  1  1 = immediate `ir[1:0]` zero-extended as operand B.
- `wren_reg`  out  1  one-cycle register-file write strobe.
- `datamem_toreg`  out  1  write-back source select: 1 = data memory, 0 = ALU.
- `link_wr`  out  1  jal: write `pc` into r3.
- `state`  out  3  debug view of the current state.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- **IDLE.** Go to FETCH when `run`=1.
- **FETCH.** Assert `imem_req`. On `imem_ack`: `ir`←`imem_rdata`, `pc`←`pc`+1 (mod 256), then go to DECODE.
- **DECODE.** Lasts one cycle. No strobes. Go to EXEC.
- **EXEC.** `alu_control` and `alu_src` are valid.
  - j: `pc`←`pc`+sext(`ir[3:0]`).
  - jal: same PC update, plus `link_wr`=1 and `wren_reg`=1 for one cycle, writing the already-incremented PC.
  - beq: taken if `alu_zero`=1; bne: taken if `alu_zero`=0. A taken branch updates `pc` the same way as j.
  - lw, sw: go to MEM.
  - All other opcodes: go to WB.
  - j, jal, beq and bne end the instruction here.
- **MEM.** Hold `dmem_req`; `dmem_we`=1 for sw. On `dmem_ack`, sw ends the instruction and lw goes to WB.
- **WB.** `wren_reg`=1 for one cycle; `datamem_toreg`=1 only for lw. End of instruction.
- **End of instruction.** Go to FETCH if `run`=1, otherwise IDLE. Deasserting `run` mid-instruction has no effect until the end of that instruction.
- **Decode map (`alu_control`, `alu_src`):**
  - move PASS,0; add ADD,0; and AND,0; not NOR,0 (datapath feeds rs to both operands); nor NOR,0.
  - slt SLT,0; sll SLL,1; srl SRL,1.
  - j PASS,0; jal PASS,0; lw ADD,1; sw ADD,1.
  - beq SUB,0; bne SUB,0; addi ADD,1; li PASS,1.
- **Outputs are Moore-style,** decoded from `state` and `ir` only.
- **Reset values:** `pc`=PC_RESET, `ir`=0, `state`=IDLE, all strobes and requests 0, `alu_control`=0, `alu_src`=0.

## Timing
- Best case, with ack in the same cycle as the request:
  - branch/jump: 3 cycles;
  - ALU ops: 4 cycles;
  - sw: 4 cycles;
  - lw: 5 cycles.
- Each wait cycle on an ack adds one cycle.
- `imem_req`/`dmem_req` rise in the first cycle of FETCH/MEM and fall the cycle after the ack is sampled.
- A `reset` sampled high aborts any state at that edge; requests are low in the next cycle. An ack arriving during reset is ignored.
- PC arithmetic is 8-bit wrapping:
  - 8'hFF+1 → 8'h00;
  - 8'h01+sext(4'b1110) → 8'hFF.
- Strobes never assert in IDLE, FETCH or DECODE.

## Structure
- Package `exceptionull_pkg`:
  - 4-bit opcode constants OP_MOVE..OP_LI (0x0..0xF);
  - `alu_control` codes PASS=000, ADD=001, SUB=010, AND=011, NOR=100, SLT=101, SLL=110, SRL=111;
  - state encoding.
- Submodule `seq_decoder`: combinational opcode→(`alu_control`, `alu_src`, class {ALU, LOAD, STORE, BRANCH, JUMP}).
- FSM, PC and IR live in the top.

## Test plan
- Reset, then `run`=1, `imem_rdata`=8'h1E (add), acks immediate → FETCH, DECODE, EXEC, WB. `alu_control`=001; `wren_reg` pulses for exactly 1 cycle; `pc`=1.
- lw 8'hA5 with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles, `dmem_we`=0; WB has `datamem_toreg`=1; 8 cycles total.
- beq 8'hCE at `pc`=4: with `alu_zero`=1, `pc` goes 5→3; with `alu_zero`=0, `pc` stays 5. bne gives the opposite outcome.
- jal 8'h93 at `pc`=8'hFE → `link_wr`=`wren_reg`=1 with `pc`=8'hFF; then `pc`=8'h02 (wrap).
- `reset` asserted in MEM while `dmem_req`=1 → next cycle `state`=IDLE, `dmem_req`=0, `pc`=PC_RESET.
- `run` dropped during EXEC of an ALU op → WB completes, `state`=IDLE, `imem_req` stays 0.
